exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameters SHALL be: N, 64, PC/ELR width; VECTOR, 64'h0000_0000_0000_00D8, exception handler entry address; ESR_IRQ, 4'b0001, ESR code for an external interrupt.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; reset in 1 asynchronous active-high reset.
REQ-003 irq_req in 1 external interrupt request (level); dec_exc in 1 decoder synchronous exception; dec_estatus in 4 decoder exception code; eret in 1 decoded ERET; pc in N PC of the current instruction.
REQ-004 pc_sel out 2 next-PC select (00 sequential/branch, 01 VECTOR, 10 ELR); exc_taken out 1 exception accepted this cycle; irq_ack out 1 interrupt acknowledge.
REQ-005 elr out N exception link register; esr out 4 exception syndrome; in_handler out 1 handler active; halted out 1 double fault; wr_inhibit out 1 suppresses RegWrite/MemWrite of the faulting instruction; exc_count out 8 accepted-exception counter.

Function
REQ-006 The FSM SHALL have three states: RUN, HANDLER and HALT.
REQ-007 In RUN with dec_exc=1, the block SHALL, in that cycle, assert exc_taken=1, pc_sel=01 and wr_inhibit=1; on the next edge it SHALL load elr<=pc and esr<=dec_estatus and move to HANDLER.
REQ-008 In RUN with dec_exc=0 and irq_pend=1, the block SHALL take the interrupt the same way, with esr<=ESR_IRQ, elr<=pc and wr_inhibit=0 (the instruction at pc is re-executed after return).
REQ-009 irq_pend SHALL be an internal flag: set on any edge where irq_req=1, irq_ack=0 and irq_pend=0; cleared on the edge the interrupt is taken.
REQ-010 irq_ack SHALL rise on the edge an interrupt is taken, stay high while irq_req=1, and fall on the first edge with irq_req=0 (4-phase handshake); no new request SHALL be latched while irq_ack=1.
REQ-011 When dec_exc and irq_pend are both set in RUN, the synchronous exception SHALL win and irq_pend SHALL remain set.
REQ-012 In HANDLER, interrupts SHALL be masked; irq_pend SHALL still be set and held.
REQ-013 In HANDLER with eret=1 and dec_exc=0, the block SHALL drive pc_sel=10 in that cycle and return to RUN on the next edge; elr and esr SHALL hold their values.
REQ-014 A pending interrupt SHALL be taken no earlier than the first RUN cycle after the ERET cycle.
REQ-015 In HANDLER with dec_exc=1 (double fault), the block SHALL assert wr_inhibit=1 and go to HALT; elr and esr SHALL keep their first-fault values.
REQ-016 In HALT, the block SHALL drive halted=1, pc_sel=01 and wr_inhibit=1 continuously; only reset exits HALT.
REQ-017 In RUN, eret=1 SHALL be ignored (pc_sel=00, no state change).
REQ-018 in_handler SHALL be 1 exactly when the state is HANDLER.
REQ-019 exc_taken SHALL be combinational from the state and inputs, and only in RUN.
REQ-020 exc_count SHALL increment on every accepted exception, including the double fault, and SHALL saturate at 8'hFF.

Reset
REQ-021 While reset=1: state=RUN, elr=0, esr=0, irq_pend=0, irq_ack=0, exc_count=0, pc_sel=00, exc_taken=0, wr_inhibit=0, halted=0.
REQ-022 Reset asserted mid-handler or in HALT SHALL discard all state immediately, without waiting for a clock edge.
REQ-023 The first active edge after reset release SHALL already sample irq_req.

Structure
REQ-024 The state enum, pc_sel encodings (PC_SEQ, PC_VEC, PC_ELR) and ESR codes (ESR_IRQ=0001, ESR_BADOP=0010) SHALL live in the shared package exc_pkg.
REQ-025 The block SHALL be a single module: FSM plus the elr/esr/counter registers.
REQ-026 One sub-module, irq_sync, SHALL implement a two-flop synchronizer for irq_req ahead of the pending logic; its added latency of 2 cycles SHALL apply to all irq timing above.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- dec_exc=1, dec_estatus=0010, pc=64'h40 in RUN -> exc_taken=1, pc_sel=01, wr_inhibit=1; next cycle elr=40, esr=0010, in_handler=1, exc_count=1.
- irq_req high at pc=64'h80 -> taken 2 cycles after sync, esr=0001, elr=80, irq_ack=1 until irq_req falls; eret -> pc_sel=10, RUN.
- irq_req and dec_exc together -> esr=0010; after eret, the IRQ is taken on the next RUN cycle with esr=0001.
- dec_exc in HANDLER -> halted=1, pc_sel=01 stuck, elr/esr keep first values; reset -> all outputs 0.
- eret in RUN -> pc_sel=00, no state change; 300 exceptions -> exc_count=FF.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception-controller types: FSM states, next-PC select encodings,
// syndrome codes and the saturating counter helper.
package exc_pkg;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      HANDLER = 2'd1,
      HALT    = 2'd2
   } exc_state_t;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_VEC = 2'b01;
   localparam logic [1:0] PC_ELR = 2'b10;

   localparam logic [3:0] ESR_IRQ   = 4'b0001;
   localparam logic [3:0] ESR_BADOP = 4'b0010;

   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? 8'hFF : value + 8'd1;
   endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bringing the asynchronous interrupt request into
// the clk domain; adds two cycles of latency to every irq decision.
module irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   output logic irq_out
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta    <= 1'b0;
         irq_out <= 1'b0;
      end else begin
         meta    <= irq_in;
         irq_out <= meta;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: RUN/HANDLER/HALT FSM that accepts synchronous
// exceptions and external interrupts, keeps ELR/ESR and counts acceptances.
module exc_ctrl #(
   parameter int           N       = 64,
   parameter logic [N-1:0] VECTOR  = 64'h0000_0000_0000_00D8,
   parameter logic [3:0]   ESR_IRQ = 4'b0001
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         irq_req,
   input  logic         dec_exc,
   input  logic [3:0]   dec_estatus,
   input  logic         eret,
   input  logic [N-1:0] pc,
   output logic [1:0]   pc_sel,
   output logic         exc_taken,
   output logic         irq_ack,
   output logic [N-1:0] elr,
   output logic [3:0]   esr,
   output logic         in_handler,
   output logic         halted,
   output logic         wr_inhibit,
   output logic [7:0]   exc_count
);

   import exc_pkg::*;

   exc_state_t state;
   exc_state_t state_next;
   logic       irq_sync_q;
   logic       irq_pend;
   logic       take_irq;
   logic       accept;

   irq_sync u_irq_sync (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_req),
      .irq_out (irq_sync_q)
   );

   // Outputs are forced to their idle values while reset is held, so a
   // decoder exception during reset can never look accepted.
   always_comb begin
      state_next = state;
      pc_sel     = PC_SEQ;
      exc_taken  = 1'b0;
      wr_inhibit = 1'b0;
      take_irq   = 1'b0;
      accept     = 1'b0;
      if (!reset) begin
         unique case (state)
            RUN: begin
               if (dec_exc) begin
                  exc_taken  = 1'b1;
                  pc_sel     = PC_VEC;
                  wr_inhibit = 1'b1;
                  accept     = 1'b1;
                  state_next = HANDLER;
               end else if (irq_pend) begin
                  exc_taken  = 1'b1;
                  pc_sel     = PC_VEC;
                  take_irq   = 1'b1;
                  accept     = 1'b1;
                  state_next = HANDLER;
               end
            end
            HANDLER: begin
               if (dec_exc) begin
                  pc_sel     = PC_VEC;
                  wr_inhibit = 1'b1;
                  accept     = 1'b1;
                  state_next = HALT;
               end else if (eret) begin
                  pc_sel     = PC_ELR;
                  state_next = RUN;
               end
            end
            HALT: begin
               pc_sel     = PC_VEC;
               wr_inhibit = 1'b1;
            end
            default: state_next = RUN;
         endcase
      end
   end

   assign in_handler = (state == HANDLER);
   assign halted     = (state == HALT);

   // A double fault only bumps the counter; ELR/ESR keep the first fault.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         elr       <= '0;
         esr       <= '0;
         exc_count <= '0;
      end else begin
         state <= state_next;
         if (exc_taken) begin
            elr <= pc;
            esr <= take_irq ? ESR_IRQ : dec_estatus;
         end
         if (accept) begin
            exc_count <= sat_inc(exc_count);
         end
      end
   end

   // Four-phase interrupt handshake: no new request is latched while the
   // previous one is still being acknowledged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_pend <= 1'b0;
         irq_ack  <= 1'b0;
      end else if (take_irq) begin
         irq_pend <= 1'b0;
         irq_ack  <= 1'b1;
      end else begin
         if (irq_sync_q && !irq_ack && !irq_pend) begin
            irq_pend <= 1'b1;
         end
         if (!irq_sync_q) begin
            irq_ack <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a behavioural model predicts every accepted
// exception, ERET and double fault; a monitor pops and compares them.
module tb_exc_ctrl;

   localparam int M_RUN     = 0;
   localparam int M_HANDLER = 1;
   localparam int M_HALT    = 2;

   localparam int K_ACCEPT = 0;
   localparam int K_DOUBLE = 1;
   localparam int K_ERET   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        irq_req = 1'b0;
   logic        dec_exc = 1'b0;
   logic [3:0]  dec_estatus = 4'h0;
   logic        eret = 1'b0;
   logic [63:0] pc = 64'h0;
   logic [1:0]  pc_sel;
   logic        exc_taken;
   logic        irq_ack;
   logic [63:0] elr;
   logic [3:0]  esr;
   logic        in_handler;
   logic        halted;
   logic        wr_inhibit;
   logic [7:0]  exc_count;

   typedef struct {
      int          cyc;
      int          kind;
      logic [1:0]  pcsel;
      logic        wrinh;
      logic        take;
      logic [63:0] elr;
      logic [3:0]  esr;
      logic [7:0]  cnt;
      logic        inh;
      logic        hlt;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   // Reference model state: what the controller should be doing, kept as
   // plain mode numbers, flags and a two-deep history of irq_req.
   int          m_mode;
   bit          m_pend;
   bit          m_ack;
   bit  [1:0]   m_dly;
   logic [63:0] m_elr;
   logic [3:0]  m_esr;
   int          m_count;

   exc_ctrl #(
      .N       (64),
      .VECTOR  (64'h0000_0000_0000_00D8),
      .ESR_IRQ (4'b0001)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq_req     (irq_req),
      .dec_exc     (dec_exc),
      .dec_estatus (dec_estatus),
      .eret        (eret),
      .pc          (pc),
      .pc_sel      (pc_sel),
      .exc_taken   (exc_taken),
      .irq_ack     (irq_ack),
      .elr         (elr),
      .esr         (esr),
      .in_handler  (in_handler),
      .halted      (halted),
      .wr_inhibit  (wr_inhibit),
      .exc_count   (exc_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic modelReset();
      m_mode  = M_RUN;
      m_pend  = 1'b0;
      m_ack   = 1'b0;
      m_dly   = 2'b00;
      m_elr   = 64'h0;
      m_esr   = 4'h0;
      m_count = 0;
   endtask

   // Drives one cycle of inputs, predicts its outcome and advances one clock.
   task automatic applyStimulus(input bit irq, input bit exc, input logic [3:0] code,
                                input bit er, input logic [63:0] p);
      bit   sync;
      bit   took;
      exp_t e;
      checkOutput("irq_ack", irq_ack, m_ack);
      checkOutput("in_handler", in_handler, m_mode == M_HANDLER);
      checkOutput("halted", halted, m_mode == M_HALT);
      irq_req     = irq;
      dec_exc     = exc;
      dec_estatus = code;
      eret        = er;
      pc          = p;
      sync = m_dly[1];
      took = 1'b0;
      e.cyc = cyc;
      if (m_mode == M_RUN && (exc || m_pend)) begin
         took    = !exc;
         m_elr   = p;
         m_esr   = exc ? code : 4'b0001;
         m_count = (m_count < 255) ? m_count + 1 : 255;
         e.kind = K_ACCEPT; e.pcsel = 2'b01; e.wrinh = exc; e.take = 1'b1;
         e.inh = 1'b1; e.hlt = 1'b0;
         m_mode = M_HANDLER;
      end else if (m_mode == M_HANDLER && exc) begin
         m_count = (m_count < 255) ? m_count + 1 : 255;
         e.kind = K_DOUBLE; e.pcsel = 2'b01; e.wrinh = 1'b1; e.take = 1'b0;
         e.inh = 1'b0; e.hlt = 1'b1;
         m_mode = M_HALT;
      end else if (m_mode == M_HANDLER && er) begin
         e.kind = K_ERET; e.pcsel = 2'b10; e.wrinh = 1'b0; e.take = 1'b0;
         e.inh = 1'b0; e.hlt = 1'b0;
         m_mode = M_RUN;
      end else begin
         e.kind = -1;
      end
      if (e.kind >= 0) begin
         e.elr = m_elr;
         e.esr = m_esr;
         e.cnt = 8'(m_count);
         expq.push_back(e);
      end
      if (took) begin
         m_pend = 1'b0;
         m_ack  = 1'b1;
      end else begin
         m_pend = m_pend | (sync & !m_ack);
         m_ack  = m_ack & sync;
      end
      m_dly = {m_dly[0], irq};
      @(posedge clk);
      #2;
   endtask

   // Asserts reset between edges, checks it acts at once, then releases it.
   task automatic doReset();
      checkOutput("pending_events", expq.size(), 0);
      reset   = 1'b1;
      irq_req = 1'b1;
      dec_exc = 1'b1;
      eret    = 1'b1;
      #1;
      checkOutput("rst_pc_sel", pc_sel, 2'b00);
      checkOutput("rst_exc_taken", exc_taken, 1'b0);
      checkOutput("rst_wr_inhibit", wr_inhibit, 1'b0);
      checkOutput("rst_halted", halted, 1'b0);
      checkOutput("rst_in_handler", in_handler, 1'b0);
      checkOutput("rst_elr", elr, 64'h0);
      checkOutput("rst_esr", esr, 4'h0);
      checkOutput("rst_exc_count", exc_count, 8'h0);
      checkOutput("rst_irq_ack", irq_ack, 1'b0);
      irq_req     = 1'b0;
      dec_exc     = 1'b0;
      eret        = 1'b0;
      dec_estatus = 4'h0;
      pc          = 64'h0;
      modelReset();
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Monitor: any cycle where the DUT accepts, returns or double-faults must
   // match the oldest predicted event, including its cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (exc_taken || pc_sel == 2'b10 || (in_handler && wr_inhibit))) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_event: got pc_sel=%0h exc_taken=%0b wr_inhibit=%0b, expected no event (cycle %0d)",
                        pc_sel, exc_taken, wr_inhibit, cyc);
            end else begin
               e = expq.pop_front();
               checkOutput("event_cycle", cyc, e.cyc);
               checkOutput("exc_taken", exc_taken, e.take);
               if (e.kind != K_DOUBLE) checkOutput("pc_sel", pc_sel, e.pcsel);
               checkOutput("wr_inhibit", wr_inhibit, e.wrinh);
               @(posedge clk);
               #1;
               checkOutput("elr", elr, e.elr);
               checkOutput("esr", esr, e.esr);
               checkOutput("exc_count", exc_count, e.cnt);
               checkOutput("post_in_handler", in_handler, e.inh);
               checkOutput("post_halted", halted, e.hlt);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: got no finish, expected finish before 1ms");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit irq_lvl;
      bit rexc;
      bit rer;
      #1;
      doReset();

      // Synchronous exception in RUN, then ERET
      applyStimulus(0, 1, 4'b0010, 0, 64'h40);
      applyStimulus(0, 0, 4'h0, 0, 64'h44);
      applyStimulus(0, 0, 4'h0, 1, 64'h48);

      // External interrupt through the synchronizer
      for (int k = 0; k < 10 && m_mode == M_RUN; k++) applyStimulus(1, 0, 4'h0, 0, 64'h80);
      repeat (3) applyStimulus(1, 0, 4'h0, 0, 64'hD8);
      repeat (4) applyStimulus(0, 0, 4'h0, 0, 64'hDC);
      applyStimulus(0, 0, 4'h0, 1, 64'hE0);
      repeat (2) applyStimulus(0, 0, 4'h0, 0, 64'h80);

      // Interrupt pending while a synchronous exception arrives
      for (int k = 0; k < 10 && !m_pend; k++) applyStimulus(1, 0, 4'h0, 0, 64'hB0);
      applyStimulus(1, 1, 4'b0010, 0, 64'hC0);
      applyStimulus(1, 0, 4'h0, 1, 64'hD8);
      applyStimulus(1, 0, 4'h0, 0, 64'hC4);
      repeat (2) applyStimulus(0, 0, 4'h0, 0, 64'hD8);
      applyStimulus(0, 0, 4'h0, 1, 64'hDC);
      repeat (4) applyStimulus(0, 0, 4'h0, 0, 64'hC4);

      // ERET in RUN is ignored
      applyStimulus(0, 0, 4'h0, 1, 64'h100);
      checkOutput("pc_sel_eret_run", pc_sel, 2'b00);
      applyStimulus(0, 0, 4'h0, 1, 64'h104);

      // Double fault then HALT until reset
      applyStimulus(0, 1, 4'b0010, 0, 64'h200);
      applyStimulus(0, 1, 4'b0111, 0, 64'h300);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 4'h0, 1, 64'h304);
         checkOutput("halt_pc_sel", pc_sel, 2'b01);
         checkOutput("halt_wr_inhibit", wr_inhibit, 1'b1);
      end
      doReset();

      // Reset mid-handler
      applyStimulus(0, 1, 4'b0101, 0, 64'h400);
      doReset();

      // Counter saturation
      for (int i = 0; i < 300; i++) begin
         applyStimulus(0, 1, 4'b0010, 0, {$urandom, $urandom});
         applyStimulus(0, 0, 4'h0, 1, 64'h0);
      end
      checkOutput("exc_count_saturated", exc_count, 8'hFF);
      doReset();

      // Random traffic
      irq_lvl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(7) == 0) irq_lvl = !irq_lvl;
         rexc = ($urandom_range(11) == 0);
         rer  = ($urandom_range(2) == 0);
         applyStimulus(irq_lvl, rexc, 4'($urandom), rer, {$urandom, $urandom});
         if (m_mode == M_HALT) begin
            applyStimulus(0, 0, 4'h0, 0, 64'h0);
            doReset();
            irq_lvl = 1'b0;
         end
      end

      repeat (2) applyStimulus(0, 0, 4'h0, 0, 64'h0);
      checkOutput("queue_empty", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
